// File: rtl/clk_mgmt_pkg.sv
// Shared types and default timing constants for the DCM reset sequencer.
package clk_mgmt_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      LOCKED    = 2'd1,
      PULSE     = 2'd2
   } ch_state_e;

   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      STABLE = 2'd1,
      RUN    = 2'd2
   } seq_state_e;

   localparam int unsigned DEF_N_DCM         = 3;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
   localparam int unsigned DEF_RESET_PULSE   = 10;
   localparam int unsigned DEF_STABLE_CYCLES = 1024;
   localparam int unsigned DEF_CNT_W         = 8;

endpackage

// File: rtl/dcm_lock_channel.sv
// One DCM: lock synchronizer, lock timeout, RST pulse generator.
// Optional saturating lock-loss counter when DCM_LOSS_COUNT_EN is defined.
module dcm_lock_channel
   import clk_mgmt_pkg::*;
#(
   parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int unsigned RESET_PULSE  = DEF_RESET_PULSE,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             locked_raw_i,
   output logic             lk_o,
   output logic             dcm_reset_o
`ifdef DCM_LOSS_COUNT_EN
   ,
   output logic [CNT_W-1:0] loss_count_o
`endif
);

   localparam int unsigned TMR_W = $clog2(LOCK_TIMEOUT + 1);

   if (RESET_PULSE < 3 || RESET_PULSE > LOCK_TIMEOUT || CNT_W == 0) begin : g_bad_param
      $error("dcm_lock_channel: illegal RESET_PULSE/LOCK_TIMEOUT/CNT_W");
   end

   logic             meta_q;
   logic             lk_q;
   ch_state_e        state_q;
   logic [TMR_W-1:0] timer_q;
   logic             dcm_reset_q;

   // The timer is shared between the lock timeout and the pulse width.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q      <= 1'b0;
         lk_q        <= 1'b0;
         state_q     <= WAIT_LOCK;
         timer_q     <= '0;
         dcm_reset_q <= 1'b0;
      end else begin
         meta_q <= locked_raw_i;
         lk_q   <= meta_q;
         case (state_q)
            WAIT_LOCK: begin
               if (lk_q) begin
                  state_q <= LOCKED;
                  timer_q <= '0;
               end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                  state_q     <= PULSE;
                  timer_q     <= '0;
                  dcm_reset_q <= 1'b1;
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            PULSE: begin
               if (timer_q == TMR_W'(RESET_PULSE - 1)) begin
                  state_q     <= WAIT_LOCK;
                  timer_q     <= '0;
                  dcm_reset_q <= 1'b0;
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            LOCKED: begin
               if (!lk_q) begin
                  state_q <= WAIT_LOCK;
                  timer_q <= '0;
               end
            end
            default: begin
               state_q     <= WAIT_LOCK;
               timer_q     <= '0;
               dcm_reset_q <= 1'b0;
            end
         endcase
      end
   end

   assign lk_o        = lk_q;
   assign dcm_reset_o = dcm_reset_q;

`ifdef DCM_LOSS_COUNT_EN
   logic             loss_q;
   logic [CNT_W-1:0] loss_cnt_q;

   // Loss flag marks the LOCKED->WAIT_LOCK edge; count lands one cycle later.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         loss_q     <= 1'b0;
         loss_cnt_q <= '0;
      end else begin
         loss_q <= (state_q == LOCKED) && !lk_q;
         if (loss_q && (loss_cnt_q != {CNT_W{1'b1}})) begin
            loss_cnt_q <= loss_cnt_q + CNT_W'(1);
         end
      end
   end

   assign loss_count_o = loss_cnt_q;
`endif

endmodule

// File: rtl/dcm_reset_sequencer.sv
// Drives DCM RST pins on lock timeout and holds system_reset until all locks are stable.
// Define DCM_LOSS_COUNT_EN to add the lock_loss_count port and per-DCM counters.
module dcm_reset_sequencer
   import clk_mgmt_pkg::*;
#(
   parameter int unsigned N_DCM         = DEF_N_DCM,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned RESET_PULSE   = DEF_RESET_PULSE,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic                   crystal_clk,
   input  logic                   reset,
   input  logic [N_DCM-1:0]       dcm_locked_in,
   output logic [N_DCM-1:0]       dcm_reset_out,
   output logic                   all_locked,
   output logic                   system_reset
`ifdef DCM_LOSS_COUNT_EN
   ,
   output logic [N_DCM*CNT_W-1:0] lock_loss_count
`endif
);

   localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);

   if (N_DCM < 1 || N_DCM > 8 || STABLE_CYCLES < 1) begin : g_bad_param
      $error("dcm_reset_sequencer: illegal N_DCM/STABLE_CYCLES");
   end

   logic [N_DCM-1:0] lk;

   for (genvar i = 0; i < N_DCM; i++) begin : g_ch
      dcm_lock_channel #(
         .LOCK_TIMEOUT (LOCK_TIMEOUT),
         .RESET_PULSE  (RESET_PULSE),
         .CNT_W        (CNT_W)
      ) u_ch (
         .clk_i        (crystal_clk),
         .reset_i      (reset),
         .locked_raw_i (dcm_locked_in[i]),
         .lk_o         (lk[i]),
         .dcm_reset_o  (dcm_reset_out[i])
`ifdef DCM_LOSS_COUNT_EN
         ,
         .loss_count_o (lock_loss_count[i*CNT_W +: CNT_W])
`endif
      );
   end

   logic             all_locked_q;
   seq_state_e       seq_q;
   logic [STB_W-1:0] stable_q;
   logic             system_reset_q;

   // Lock loss is checked before stable-count completion so it wins a tie.
   always_ff @(posedge crystal_clk) begin
      if (reset) begin
         all_locked_q   <= 1'b0;
         seq_q          <= HOLD;
         stable_q       <= '0;
         system_reset_q <= 1'b1;
      end else begin
         all_locked_q <= &lk;
         case (seq_q)
            HOLD: begin
               if (all_locked_q) begin
                  seq_q    <= STABLE;
                  stable_q <= '0;
               end
            end
            STABLE: begin
               if (!all_locked_q) begin
                  seq_q <= HOLD;
               end else if (stable_q == STB_W'(STABLE_CYCLES - 1)) begin
                  seq_q          <= RUN;
                  system_reset_q <= 1'b0;
               end else begin
                  stable_q <= stable_q + STB_W'(1);
               end
            end
            RUN: begin
               if (!all_locked_q) begin
                  seq_q          <= HOLD;
                  system_reset_q <= 1'b1;
               end
            end
            default: begin
               seq_q          <= HOLD;
               system_reset_q <= 1'b1;
            end
         endcase
      end
   end

   assign all_locked   = all_locked_q;
   assign system_reset = system_reset_q;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Scoreboard bench for dcm_reset_sequencer (N_DCM=3, LOCK_TIMEOUT=20, RESET_PULSE=4, STABLE_CYCLES=16).
module tb_dcm_reset_sequencer;

   localparam int unsigned N  = 3;
   localparam int unsigned LT = 20;
   localparam int unsigned RP = 4;
   localparam int unsigned SC = 16;
   localparam int unsigned CW = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] raw;
   logic [N-1:0] dcm_reset_out;
   logic         all_locked;
   logic         system_reset;
`ifdef DCM_LOSS_COUNT_EN
   logic [N*CW-1:0] lock_loss_count;
`endif

   dcm_reset_sequencer #(
      .N_DCM         (N),
      .LOCK_TIMEOUT  (LT),
      .RESET_PULSE   (RP),
      .STABLE_CYCLES (SC),
      .CNT_W         (CW)
   ) dut (
      .crystal_clk     (clk),
      .reset           (rst),
      .dcm_locked_in   (raw),
      .dcm_reset_out   (dcm_reset_out),
      .all_locked      (all_locked),
      .system_reset    (system_reset)
`ifdef DCM_LOSS_COUNT_EN
      ,
      .lock_loss_count (lock_loss_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int           k;
      logic [N-1:0] rsto;
      logic         al;
      logic         sr;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Two reset cycles with the given locks, then release; edge k=1 is the first un-reset edge.
   task automatic apply_reset(input logic [N-1:0] locks);
      rst = 1'b1;
      raw = locks;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      raw = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({dcm_reset_out, all_locked, system_reset} !== {3'b000, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL reset_state got=%b want=%b", {dcm_reset_out, all_locked, system_reset}, 5'b00001);
      end
      rst = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         e.k = k; e.rsto = '0; e.al = (k >= 3); e.sr = (k < 20);
         exp_q.push_back(e);
      end
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if ({dcm_reset_out, all_locked, system_reset} !== {e.rsto, e.al, e.sr}) begin
            bad++;
            $display("FAIL power_up k=%0d got=%b want=%b", e.k,
                     {dcm_reset_out, all_locked, system_reset}, {e.rsto, e.al, e.sr});
         end
      end
   endtask

   task automatic test_timeout_pulse();
      exp_t e;
      apply_reset(3'b011);
      for (int k = 1; k <= 60; k++) begin
         e.k = k;
         e.rsto = (k >= 20 && ((k - 20) % 24) < 4) ? 3'b100 : 3'b000;
         e.al = 1'b0; e.sr = 1'b1;
         exp_q.push_back(e);
      end
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if ({dcm_reset_out, all_locked, system_reset} !== {e.rsto, e.al, e.sr}) begin
            bad++;
            $display("FAIL timeout_pulse k=%0d got=%b want=%b", e.k,
                     {dcm_reset_out, all_locked, system_reset}, {e.rsto, e.al, e.sr});
         end
      end
   endtask

   task automatic test_glitch_in_run();
      exp_t e;
      apply_reset(3'b111);
      for (int k = 1; k <= 50; k++) begin
         e.k = k; e.rsto = '0;
         e.al = (k >= 3) && (k != 28);
         e.sr = (k < 20) || (k >= 29 && k < 46);
         exp_q.push_back(e);
      end
      for (int k = 1; k <= 50; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if ({dcm_reset_out, all_locked, system_reset} !== {e.rsto, e.al, e.sr}) begin
            bad++;
            $display("FAIL glitch_run k=%0d got=%b want=%b", e.k,
                     {dcm_reset_out, all_locked, system_reset}, {e.rsto, e.al, e.sr});
         end
         if (k == 25) raw = 3'b101;
         if (k == 26) raw = 3'b111;
      end
`ifdef DCM_LOSS_COUNT_EN
      total++;
      if (lock_loss_count !== {2'd0, 2'd1, 2'd0}) begin
         bad++;
         $display("FAIL glitch_count got=%h want=%h", lock_loss_count, 6'h04);
      end
`endif
   endtask

   task automatic test_drop_at_stable_end();
      exp_t e;
      apply_reset(3'b111);
      for (int k = 1; k <= 45; k++) begin
         e.k = k; e.rsto = '0;
         e.al = (k >= 3) && (k != 19);
         e.sr = (k < 37);
         exp_q.push_back(e);
      end
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if ({dcm_reset_out, all_locked, system_reset} !== {e.rsto, e.al, e.sr}) begin
            bad++;
            $display("FAIL stable_tie k=%0d got=%b want=%b", e.k,
                     {dcm_reset_out, all_locked, system_reset}, {e.rsto, e.al, e.sr});
         end
         if (k == 16) raw = 3'b110;
         if (k == 17) raw = 3'b111;
      end
   endtask

   task automatic test_reset_mid_pulse();
      exp_t e;
      apply_reset(3'b110);
      for (int k = 1; k <= 22; k++) begin
         e.k = k;
         e.rsto = (k == 20 || k == 21) ? 3'b001 : 3'b000;
         e.al = 1'b0; e.sr = 1'b1;
         exp_q.push_back(e);
      end
      for (int k = 1; k <= 22; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if ({dcm_reset_out, all_locked, system_reset} !== {e.rsto, e.al, e.sr}) begin
            bad++;
            $display("FAIL mid_pulse_reset k=%0d got=%b want=%b", e.k,
                     {dcm_reset_out, all_locked, system_reset}, {e.rsto, e.al, e.sr});
         end
         if (k == 5) raw = 3'b100;
         if (k == 6) raw = 3'b110;
`ifdef DCM_LOSS_COUNT_EN
         if (k == 15) begin
            total++;
            if (lock_loss_count[1*CW +: CW] !== 2'd1) begin
               bad++;
               $display("FAIL pre_reset_count got=%0d want=1", lock_loss_count[1*CW +: CW]);
            end
         end
`endif
         if (k == 21) rst = 1'b1;
      end
`ifdef DCM_LOSS_COUNT_EN
      total++;
      if (lock_loss_count !== '0) begin
         bad++;
         $display("FAIL post_reset_count got=%h want=0", lock_loss_count);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_loss_saturation();
      exp_t e;
      apply_reset(3'b111);
      for (int k = 1; k <= 40; k++) begin
         e.k = k; e.rsto = '0;
         e.al = (k >= 3) && !(k >= 13 && k <= 29 && ((k - 13) % 4) == 0);
         e.sr = 1'b1;
         exp_q.push_back(e);
      end
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if ({dcm_reset_out, all_locked, system_reset} !== {e.rsto, e.al, e.sr}) begin
            bad++;
            $display("FAIL toggles k=%0d got=%b want=%b", e.k,
                     {dcm_reset_out, all_locked, system_reset}, {e.rsto, e.al, e.sr});
         end
         if (k >= 10 && k <= 26 && ((k - 10) % 4) == 0) raw = 3'b011;
         else raw = 3'b111;
      end
`ifdef DCM_LOSS_COUNT_EN
      total++;
      if (lock_loss_count !== {2'd3, 2'd0, 2'd0}) begin
         bad++;
         $display("FAIL saturation got=%h want=%h", lock_loss_count, 6'h30);
      end
`endif
   endtask

   initial begin
      rst = 1'b1;
      raw = '0;
      test_reset();
      test_timeout_pulse();
      test_glitch_in_run();
      test_drop_at_stable_end();
      test_reset_mid_pulse();
      test_loss_saturation();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dcm_reset_sequencer.md
# dcm_reset_sequencer

Sits directly downstream of the clock manager. Consumes the raw `LOCKED` flags of up to N_DCM DCM_SP instances and drives their `RST` inputs: a DCM that fails to lock within a timeout gets a fixed-width reset pulse. Holds a registered, design-wide `system_reset` until every DCM has stayed locked for a stability window, and reasserts it on any lock loss. All logic runs on the crystal clock, so it keeps working while the DCM outputs are dead.

## Interface
- `N_DCM`, 3: number of monitored DCMs (1–8).
- `LOCK_TIMEOUT`, 50000: cycles a lock may stay low before that DCM is reset.
- `RESET_PULSE`, 10: width in cycles of each `dcm_reset_out` pulse (≥3).
- `STABLE_CYCLES`, 1024: cycles all locks must stay high before `system_reset` is released.
- `CNT_W`, 8: width of each lock-loss counter.

Ports:
- `crystal_clk` in 1: free-running board oscillator clock.
- `reset` in 1: synchronous, active-high.
- `dcm_locked_in` in N_DCM: raw DCM `LOCKED` flags, asynchronous to `crystal_clk`.
- `dcm_reset_out` out N_DCM: to the DCM `RST` pins, active-high.
- `all_locked` out 1: all synchronized locks are high.
- `system_reset` out 1: active-high reset for the rest of the design.
- `lock_loss_count` out N_DCM*CNT_W: per-DCM lock-loss counters, DCM i in bits [i*CNT_W +: CNT_W]. Present only with `DCM_LOSS_COUNT_EN`.

## Operation
Reset values: `dcm_reset_out`=0, `all_locked`=0, `system_reset`=1, counters=0. The channel FSMs enter WAIT_LOCK with timer 0. The sequencer enters HOLD. Asserting `reset` does not pulse any DCM.

- **Input synchronization:** each `dcm_locked_in` bit passes through a 2-flop synchronizer. The result is `lk[i]`.
- **Channel FSM (one per DCM):**
  - WAIT_LOCK:
    - `lk` high → LOCKED; timer cleared.
    - `lk` low → timer increments.
    - timer == LOCK_TIMEOUT-1 with `lk` low → PULSE; timer cleared.
  - PULSE:
    - `dcm_reset_out[i]`=1.
    - `lk` is ignored.
    - After RESET_PULSE cycles → WAIT_LOCK, timer 0.
  - LOCKED:
    - `lk` low → WAIT_LOCK, timer 0, lock-loss event.
- **Timer width:** `$clog2(LOCK_TIMEOUT+1)`. The timer never wraps.
- **Sequencer FSM:**
  - HOLD:
    - `system_reset`=1.
    - `all_locked` high → STABLE with counter 0.
  - STABLE:
    - `system_reset`=1; counter increments.
    - `all_locked` low → HOLD.
    - counter == STABLE_CYCLES-1 → RUN.
  - RUN:
    - `system_reset`=0.
    - `all_locked` low → HOLD.
- **Lock-loss events:** a DCM that is in PULSE also has `lk` low, so a pulse forces the sequencer out of RUN.
- **Simultaneous events:** lock loss and stable-count completion in the same cycle → HOLD. Lock loss takes priority.

## Timing
- `lk` lags `dcm_locked_in` by 2 cycles.
- `all_locked` is registered: it is the AND of `lk`, one cycle later.
- `dcm_reset_out` is registered from the channel state. It rises on the first cycle in PULSE, which is LOCK_TIMEOUT cycles after entering WAIT_LOCK with `lk` continuously low. It stays high for exactly RESET_PULSE cycles.
- `system_reset` is registered from the sequencer state.
  - Deassertion: STABLE_CYCLES+1 cycles after `all_locked` rises, provided no drop occurs.
  - Reassertion: 1 cycle after `all_locked` falls, i.e. 4 cycles after a raw lock drop.
- A `lk` glitch of one cycle in LOCKED counts as a loss and restarts the timeout. There is no filtering.
- Mid-operation `reset`: all outputs return to reset values on the next edge. Any in-progress pulse is truncated.

## Configuration
- **`DCM_LOSS_COUNT_EN` defined:**
  - Per-DCM saturating counters of LOCKED→WAIT_LOCK transitions are included.
  - Each counter increments on the cycle after the transition and saturates at 2^CNT_W-1.
  - They are cleared only by `reset` and are exported on `lock_loss_count`.
- **Not defined:** the counters and the `lock_loss_count` port are absent.
- Channel and sequencer behaviour is identical in both builds.

## Structure
- **Package `clk_mgmt_pkg`:** channel state enum (WAIT_LOCK, LOCKED, PULSE), sequencer state enum (HOLD, STABLE, RUN), and default timing constants.
- **Sub-module `dcm_lock_channel`:** synchronizer, timer, channel FSM and optional counter. Instantiated N_DCM times via generate. The top level holds the AND-reduce and the sequencer.

## Test plan
All scenarios use N_DCM=3, LOCK_TIMEOUT=20, RESET_PULSE=4, STABLE_CYCLES=16.

1. `reset` high 2 cycles, all locks tied high → `all_locked` rises at cycle 3 after release; `system_reset` falls 17 cycles later; `dcm_reset_out`=0 throughout.
2. `dcm_locked_in`=3'b011 held → `dcm_reset_out[2]` rises 20 cycles after release, stays high 4 cycles, and repeats every 24 cycles; `system_reset` stays 1.
3. Running system, drop `dcm_locked_in[1]` for 1 cycle → `system_reset` reasserts 4 cycles after the drop; release is restarted; the loss counter for DCM 1 reads 1 (with `DCM_LOSS_COUNT_EN`).
4. Drop a lock at STABLE count 15 → HOLD; `system_reset` never falls in that window.
5. Assert `reset` mid-pulse on DCM 0 → `dcm_reset_out[0]`=0 on the next cycle and counters read 0.
6. With `DCM_LOSS_COUNT_EN` and CNT_W=2, toggle lock 5 times → counter saturates at 3.
